// File: rtl/game_countdown_if.sv
// game_countdown_if: control inputs and display/status outputs of the countdown timer.
interface game_countdown_if;
    logic        i_Load;
    logic [11:0] i_Preset;
    logic        i_Start;
    logic        i_Pause;
    logic [6:0]  o_FND0;
    logic [6:0]  o_FND1;
    logic [6:0]  o_FND2;
    logic        o_Running;
    logic        o_Done;
    modport master (output i_Load, i_Preset, i_Start, i_Pause, input o_FND0, o_FND1, o_FND2, o_Running, o_Done);
    modport slave (input i_Load, i_Preset, i_Start, i_Pause, output o_FND0, o_FND1, o_FND2, o_Running, o_Done);
endinterface

// File: rtl/game_countdown.sv
// game_countdown: 3-digit BCD countdown timer with load/start/pause and 7-segment outputs.
module game_countdown #(
    parameter int LST_CLK = 49_999_999
) (
    input logic            i_Clk,
    input logic            i_Rst,
    game_countdown_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t      r_state;
    logic [3:0]  r_d0, r_d1, r_d2;
    logic [26:0] r_cnt;
    logic        r_done;
    logic        w_tick, w_b0, w_b1, w_one, w_zero;
    function automatic logic [3:0] clamp(input logic [3:0] n);
        return n > 4'd9 ? 4'd9 : n;
    endfunction
    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction
    assign w_tick = r_state == RUN && r_cnt == 27'(LST_CLK);
    assign w_b0   = r_d0 == 4'd0;
    assign w_b1   = w_b0 && r_d1 == 4'd0;
    assign w_one  = {r_d2, r_d1, r_d0} == 12'h001;
    assign w_zero = {r_d2, r_d1, r_d0} == 12'h000;
    // RUN never holds 000, so the hundreds digit cannot underflow.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state <= IDLE;
            r_d0    <= 4'd0;
            r_d1    <= 4'd0;
            r_d2    <= 4'd0;
            r_cnt   <= 27'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.i_Load) begin
                r_d0    <= clamp(bus.i_Preset[3:0]);
                r_d1    <= clamp(bus.i_Preset[7:4]);
                r_d2    <= clamp(bus.i_Preset[11:8]);
                r_cnt   <= 27'd0;
                r_state <= IDLE;
            end else begin
                if (r_state == RUN) r_cnt <= w_tick ? 27'd0 : r_cnt + 27'd1;
                if (w_tick) begin
                    r_d0 <= w_b0 ? 4'd9 : r_d0 - 4'd1;
                    r_d1 <= w_b0 ? (r_d1 == 4'd0 ? 4'd9 : r_d1 - 4'd1) : r_d1;
                    r_d2 <= w_b1 ? r_d2 - 4'd1 : r_d2;
                end
                if (w_tick && w_one) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end else if (bus.i_Start && (r_state == IDLE || r_state == PAUSE) && !w_zero)
                    r_state <= RUN;
                else if (bus.i_Pause && r_state == RUN)
                    r_state <= PAUSE;
            end
        end
    end
    assign bus.o_FND0    = seg(r_d0);
    assign bus.o_FND1    = seg(r_d1);
    assign bus.o_FND2    = seg(r_d2);
    assign bus.o_Running = r_state == RUN;
    assign bus.o_Done    = r_done;
endmodule

// File: tb/tb_game_countdown.sv
// tb_game_countdown: vector table, corner sequences and random run against an integer countdown model.
module tb_game_countdown;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    logic [6:0] lut [10];
    int m_val, m_mode, m_el;
    logic m_done;
    game_countdown_if bus ();
    game_countdown #(.LST_CLK(3)) dut (.i_Clk(clk), .i_Rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic        rst;
        logic        ld;
        logic [11:0] pre;
        logic        st;
        logic        pa;
        int          idle;
        logic [11:0] d;
        logic        run;
        logic        dn;
    } vec_t;
    vec_t vec [15];
    function automatic int clampn(input logic [3:0] n);
        return n > 4'd9 ? 9 : int'(n);
    endfunction
    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction
    function automatic logic [22:0] expv(input logic [11:0] d, input logic run, input logic dn);
        return {lut[d[11:8]], lut[d[7:4]], lut[d[3:0]], run, dn};
    endfunction
    // Model: mode 0 idle, 1 run, 2 pause, 3 done; a tick every 4th running cycle.
    task automatic model(input logic r, ld, input logic [11:0] pre, input logic st, pa);
        if (r) begin
            m_val = 0; m_mode = 0; m_el = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (ld) begin
                m_val = 100 * clampn(pre[11:8]) + 10 * clampn(pre[7:4]) + clampn(pre[3:0]);
                m_el = 0; m_mode = 0;
            end else begin
                if (m_mode == 1) begin
                    m_el++;
                    if (m_el == 4) begin
                        m_el = 0;
                        m_val--;
                        if (m_val == 0) begin
                            m_mode = 3; m_done = 1'b1;
                        end
                    end
                end
                if (!m_done) begin
                    if (st && (m_mode == 0 || m_mode == 2) && m_val != 0) m_mode = 1;
                    else if (pa && m_mode == 1) m_mode = 2;
                end
            end
        end
    endtask
    task automatic step(input logic r, ld, input logic [11:0] pre, input logic st, pa);
        @(negedge clk);
        rst = r; bus.i_Load = ld; bus.i_Preset = pre; bus.i_Start = st; bus.i_Pause = pa;
        @(posedge clk);
        model(r, ld, pre, st, pa);
        #1;
    endtask
    task automatic nop(input int n);
        repeat (n) step(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    endtask
    task automatic chk(input string nm, input logic [22:0] exp);
        logic [22:0] act;
        act = {bus.o_FND2, bus.o_FND1, bus.o_FND0, bus.o_Running, bus.o_Done};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask
    task automatic chk_model(input string nm);
        chk(nm, expv(to_bcd(m_val), m_mode == 1, m_done));
    endtask
    initial begin
        lut[0] = 7'b1000000; lut[1] = 7'b1111001; lut[2] = 7'b0100100; lut[3] = 7'b0110000;
        lut[4] = 7'b0011001; lut[5] = 7'b0010010; lut[6] = 7'b0000010; lut[7] = 7'b1111000;
        lut[8] = 7'b0000000; lut[9] = 7'b0010000;
        rst = 1'b1; bus.i_Load = 1'b0; bus.i_Preset = 12'h000; bus.i_Start = 1'b0; bus.i_Pause = 1'b0;
        m_val = 0; m_mode = 0; m_el = 0; m_done = 1'b0;
        vec[0]  = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 0,  12'h000, 1'b0, 1'b0};
        vec[1]  = '{1'b0, 1'b1, 12'h010, 1'b0, 1'b0, 0,  12'h010, 1'b0, 1'b0};
        vec[2]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 0,  12'h010, 1'b1, 1'b0};
        vec[3]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3,  12'h009, 1'b1, 1'b0};
        vec[4]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 34, 12'h001, 1'b1, 1'b0};
        vec[5]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 0,  12'h000, 1'b0, 1'b1};
        vec[6]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 0,  12'h000, 1'b0, 1'b0};
        vec[7]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 5,  12'h000, 1'b0, 1'b0};
        vec[8]  = '{1'b0, 1'b1, 12'h100, 1'b0, 1'b0, 0,  12'h100, 1'b0, 1'b0};
        vec[9]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 4,  12'h099, 1'b1, 1'b0};
        vec[10] = '{1'b0, 1'b1, 12'h0FA, 1'b0, 1'b0, 0,  12'h099, 1'b0, 1'b0};
        vec[11] = '{1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 0,  12'h000, 1'b0, 1'b0};
        vec[12] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 6,  12'h000, 1'b0, 1'b0};
        vec[13] = '{1'b0, 1'b1, 12'hFC7, 1'b0, 1'b0, 0,  12'h997, 1'b0, 1'b0};
        vec[14] = '{1'b1, 1'b1, 12'h777, 1'b0, 1'b0, 0,  12'h000, 1'b0, 1'b0};
        for (int i = 0; i < 15; i++) begin
            step(vec[i].rst, vec[i].ld, vec[i].pre, vec[i].st, vec[i].pa);
            nop(vec[i].idle);
            chk($sformatf("vec%0d", i), expv(vec[i].d, vec[i].run, vec[i].dn));
        end
        // Pause two cycles into a period; resume finishes the remaining two cycles.
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 12'h005, 1'b0, 1'b0);
        step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        nop(1);
        step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        chk("pause_enter", expv(12'h005, 1'b0, 1'b0));
        nop(20);
        chk("pause_hold", expv(12'h005, 1'b0, 1'b0));
        step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        chk("resume", expv(12'h005, 1'b1, 1'b0));
        nop(1);
        chk("resume_p1", expv(12'h005, 1'b1, 1'b0));
        nop(1);
        chk("resume_tick", expv(12'h004, 1'b1, 1'b0));
        // Load on a tick cycle wins over the decrement.
        step(1'b0, 1'b1, 12'h050, 1'b0, 1'b0);
        step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        nop(3);
        step(1'b0, 1'b1, 12'h321, 1'b0, 1'b0);
        chk("load_on_tick", expv(12'h321, 1'b0, 1'b0));
        step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        nop(5);
        chk("run_320", expv(12'h320, 1'b1, 1'b0));
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        chk("rst_mid_run", expv(12'h000, 1'b0, 1'b0));
        nop(8);
        chk("rst_no_done", expv(12'h000, 1'b0, 1'b0));
        // Pause on a tick applies it; pause on the final tick yields DONE.
        step(1'b0, 1'b1, 12'h002, 1'b0, 1'b0);
        step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        nop(3);
        step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        chk("pause_tick", expv(12'h001, 1'b0, 1'b0));
        step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        nop(3);
        step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        chk("done_over_pause", expv(12'h000, 1'b0, 1'b1));
        step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        chk("done_hold", expv(12'h000, 1'b0, 1'b0));
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic r, ld, st, pa;
            logic [11:0] pre;
            int k;
            r = $urandom_range(299) == 0;
            ld = $urandom_range(49) == 0;
            pre = ($urandom_range(2) == 0) ? 12'($urandom) : {8'h00, 4'($urandom_range(9))};
            k = $urandom_range(17);
            st = k == 0;
            pa = k == 1;
            step(r, ld, pre, st, pa);
            chk_model("rand");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/game_countdown.md
GAME_COUNTDOWN -- requirements
Module: game_countdown

Interface
REQ-001 SHALL have parameter LST_CLK, default 49_999_999; the tick period is LST_CLK+1 clock cycles (1 s at 50 MHz).
REQ-002 SHALL have port i_Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_Rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_Load, input, 1 bit: one-cycle pulse that loads i_Preset.
REQ-005 SHALL have port i_Preset, input, 12 bits: BCD preset as {hundreds[11:8], tens[7:4], units[3:0]}.
REQ-006 SHALL have port i_Start, input, 1 bit: one-cycle pulse that starts or resumes the count.
REQ-007 SHALL have port i_Pause, input, 1 bit: one-cycle pulse that pauses the count.
REQ-008 SHALL have ports o_FND0, o_FND1, o_FND2, output, 7 bits each: segments for units, tens and hundreds; bit order {g,f,e,d,c,b,a}; active-low.
REQ-009 SHALL have port o_Running, output, 1 bit: high while in state RUN.
REQ-010 SHALL have port o_Done, output, 1 bit: one-cycle pulse on expiry.

Function
REQ-011 SHALL hold three registered BCD digits D0 (units), D1 (tens) and D2 (hundreds), plus a 27-bit tick counter.
REQ-012 SHALL implement states IDLE, RUN, PAUSE and DONE.
REQ-013 SHALL give input priority per cycle as i_Load > i_Start > i_Pause.
REQ-014 SHALL, on i_Load in any state, load the digits from i_Preset, clamping any nibble >9 to 9, clear the tick counter, and enter IDLE on the next cycle.
REQ-015 SHALL, on i_Start in IDLE or PAUSE, enter RUN if the digits are non-zero; with digits equal to 000 it SHALL stay in the current state.
REQ-016 SHALL ignore i_Start in RUN and in DONE.
REQ-017 SHALL, on i_Pause in RUN, enter PAUSE with the tick counter frozen (not cleared); i_Pause SHALL be ignored in all other states.
REQ-018 SHALL, in RUN only, advance the tick counter by 1 per cycle, wrapping LST_CLK -> 0; the wrap cycle is the tick.
REQ-019 SHALL, on a tick, decrement the 3-digit value by 1 with a BCD borrow chain:
- D0 0 -> 9 and borrows from D1; otherwise D0-1.
- D1 0 -> 9 and borrows from D2 only when D0 borrows.
- D2 decrements only when D1 borrows.
REQ-020 SHALL, when a tick takes the value from 001 to 000, enter DONE and assert o_Done for exactly that one register-update cycle (registered; high in the first cycle of DONE).
REQ-021 SHALL hold DONE with digits 000 until i_Load or reset; no wrap to 999 is ever permitted.
REQ-022 SHALL, when a tick coincides with i_Pause, apply the decrement and enter PAUSE; when the tick reaches 000, DONE wins over PAUSE.
REQ-023 SHALL, when i_Load coincides with a tick, load i_Preset and not apply the decrement.
REQ-024 SHALL drive the segment outputs combinationally from the digit registers with the decode 0-9 standard, active-low; the code for 0 is 7'b1000000 and for 9 is 7'b0010000.
REQ-025 SHALL drive o_Running as a decode of state == RUN.

Reset
REQ-026 SHALL, with i_Rst high at a clock edge, set state IDLE, D0, D1 and D2 to 0, the tick counter to 0, o_Done to 0 and o_Running to 0; all three FND outputs SHALL read 7'b1000000.
REQ-027 SHALL give reset priority over all inputs, including mid-RUN and in the same cycle as i_Load.

Verification (LST_CLK=3, i.e. a tick every 4 cycles)
REQ-028 Reset then i_Load with i_Preset=12'h010, then i_Start -> o_Running=1; after 4 cycles digits 009 (o_FND1=1000000, o_FND0=0010000); after 40 cycles from start, o_Done pulses once and the digits hold 000.
REQ-029 i_Preset=12'h100, run one tick -> digits 099 via a double borrow.
REQ-030 i_Preset=12'h0FA -> loaded value 099; i_Start with 12'h000 loaded -> state stays IDLE and o_Running=0.
REQ-031 Run 005, i_Pause 2 cycles into a tick period, wait 20 cycles -> digits unchanged; i_Start -> next decrement 2 cycles later.
REQ-032 i_Load with 12'h321 on a tick cycle -> digits 321, IDLE; i_Rst asserted mid-RUN -> 000 and IDLE next cycle, no o_Done.
